// File: rtl/instr_check_monitor_pkg.sv
// Shared definitions for the SAP-2 instruction-level check monitor.
// State constants stay plain logic vectors so legacy benches can compare them directly.
package instr_check_monitor_pkg;

   localparam int unsigned MON_DATA_WIDTH = 8;

   typedef logic [2:0] mon_state_t;

   localparam mon_state_t MON_IDLE       = 3'd0;
   localparam mon_state_t MON_WAIT_INSTR = 3'd1;
   localparam mon_state_t MON_SAMPLE     = 3'd2;
   localparam mon_state_t MON_WAIT_HALT  = 3'd3;
   localparam mon_state_t MON_DONE       = 3'd4;

endpackage

// File: rtl/instr_check_monitor_if.sv
// CPU observation and expectation-table write bus of the check monitor.
// The master side (bench or self-test sequencer) drives it; the monitor consumes it.
interface instr_check_monitor_if
   import instr_check_monitor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MON_DATA_WIDTH,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned MAX_STEPS  = 16
);
   localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);

   logic                         instr_complete;
   logic                         halt;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_value;
   logic                         exp_wr_en;
   logic [STEP_W-1:0]            exp_wr_step;
   logic [NUM_CH*DATA_WIDTH-1:0] exp_wr_data;
   logic [NUM_CH-1:0]            exp_wr_mask;

   modport master (
      output instr_complete, halt, ch_value,
      output exp_wr_en, exp_wr_step, exp_wr_data, exp_wr_mask
   );

   modport slave (
      input instr_complete, halt, ch_value,
      input exp_wr_en, exp_wr_step, exp_wr_data, exp_wr_mask
   );

endinterface

// File: rtl/instr_check_monitor_exp_table.sv
// Per-step expectation table: one write port, one asynchronous read port.
// Only the masks are reset, so an unwritten entry compares nothing.
module mon_exp_table
   import instr_check_monitor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MON_DATA_WIDTH,
   parameter int unsigned NUM_CH     = 4,
   parameter int unsigned MAX_STEPS  = 16,
   parameter int unsigned STEP_W     = $clog2(MAX_STEPS + 1),
   parameter int unsigned IDX_W      = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         wr_en,
   input  logic [STEP_W-1:0]            wr_step,
   input  logic [NUM_CH*DATA_WIDTH-1:0] wr_data,
   input  logic [NUM_CH-1:0]            wr_mask,
   input  logic [IDX_W-1:0]             rd_step,
   output logic [NUM_CH*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_CH-1:0]            rd_mask
);

   logic [NUM_CH*DATA_WIDTH-1:0] data_q [MAX_STEPS];
   logic [NUM_CH-1:0]            mask_q [MAX_STEPS];
   logic                         wr_ok;
   logic [IDX_W-1:0]             wr_idx;

   assign wr_ok  = wr_en && (wr_step < STEP_W'(MAX_STEPS));
   assign wr_idx = wr_step[IDX_W-1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < MAX_STEPS; i++) begin
            mask_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mask_q[wr_idx] <= wr_mask;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         data_q[wr_idx] <= wr_data;
      end
   end

   assign rd_data = data_q[rd_step];
   assign rd_mask = mask_q[rd_step];

endmodule

// File: rtl/instr_check_monitor.sv
// Instruction-level checker: samples CPU state one cycle after each retire,
// compares against the expectation table, then enforces a halt deadline.
module instr_check_monitor
   import instr_check_monitor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH   = MON_DATA_WIDTH,
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned MAX_STEPS    = 16,
   parameter int unsigned HALT_TIMEOUT = 20,
   localparam int unsigned STEP_W      = $clog2(MAX_STEPS + 1)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   start,
   input  logic [STEP_W-1:0]      num_steps,
   instr_check_monitor_if.slave   bus,
   output logic                   busy,
   output logic                   done,
   output logic                   pass,
   output logic [STEP_W-1:0]      fail_count,
   output logic [STEP_W-1:0]      first_fail_step,
   output logic [NUM_CH-1:0]      first_fail_ch,
   output logic                   timeout_err,
   output logic                   early_halt_err,
   output logic                   overrun_err
);

   localparam int unsigned       TMR_W    = $clog2(HALT_TIMEOUT + 1);
   localparam int unsigned       IDX_W    = (MAX_STEPS > 1) ? $clog2(MAX_STEPS) : 1;
   localparam logic [STEP_W-1:0] STEP_MAX = STEP_W'(MAX_STEPS);
   localparam logic [STEP_W-1:0] CNT_SAT  = '1;
   localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(HALT_TIMEOUT - 1);

   mon_state_t        state_q, state_d;
   logic [STEP_W-1:0] step_idx_q, step_idx_d;
   logic [STEP_W-1:0] num_q, num_d;
   logic [TMR_W-1:0]  timer_q, timer_d;
   logic [STEP_W-1:0] fail_cnt_q, fail_cnt_d;
   logic [STEP_W-1:0] ff_step_q, ff_step_d;
   logic [NUM_CH-1:0] ff_ch_q, ff_ch_d;
   logic              to_q, to_d;
   logic              eh_q, eh_d;
   logic              ov_q, ov_d;

   logic [NUM_CH*DATA_WIDTH-1:0] exp_data;
   logic [NUM_CH-1:0]            exp_mask;
   logic [NUM_CH-1:0]            ch_ne;
   logic [NUM_CH-1:0]            mism;

   assign busy = (state_q == MON_WAIT_INSTR) || (state_q == MON_SAMPLE) ||
                 (state_q == MON_WAIT_HALT);

   mon_exp_table #(
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_CH     (NUM_CH),
      .MAX_STEPS  (MAX_STEPS),
      .STEP_W     (STEP_W),
      .IDX_W      (IDX_W)
   ) u_table (
      .clk     (clk),
      .reset_n (reset_n),
      .wr_en   (bus.exp_wr_en && !busy),
      .wr_step (bus.exp_wr_step),
      .wr_data (bus.exp_wr_data),
      .wr_mask (bus.exp_wr_mask),
      .rd_step (step_idx_q[IDX_W-1:0]),
      .rd_data (exp_data),
      .rd_mask (exp_mask)
   );

   always_comb begin
      ch_ne = '0;
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         ch_ne[c] = bus.ch_value[c*DATA_WIDTH +: DATA_WIDTH] !=
                    exp_data[c*DATA_WIDTH +: DATA_WIDTH];
      end
      mism = ch_ne & exp_mask;
   end

   always_comb begin
      state_d    = state_q;
      step_idx_d = step_idx_q;
      num_d      = num_q;
      timer_d    = timer_q;
      fail_cnt_d = fail_cnt_q;
      ff_step_d  = ff_step_q;
      ff_ch_d    = ff_ch_q;
      to_d       = to_q;
      eh_d       = eh_q;
      ov_d       = ov_q;
      case (state_q)
         MON_IDLE, MON_DONE: begin
            if (start) begin
               state_d    = (num_steps == '0) ? MON_WAIT_HALT : MON_WAIT_INSTR;
               step_idx_d = '0;
               timer_d    = '0;
               num_d      = (num_steps > STEP_MAX) ? STEP_MAX : num_steps;
               fail_cnt_d = '0;
               ff_step_d  = '1;
               ff_ch_d    = '0;
               to_d       = 1'b0;
               eh_d       = 1'b0;
               ov_d       = 1'b0;
            end
         end
         MON_WAIT_INSTR: begin
            if (bus.halt) begin
               eh_d    = 1'b1;
               state_d = MON_DONE;
            end else if (bus.instr_complete) begin
               state_d = MON_SAMPLE;
            end
         end
         MON_SAMPLE: begin
            // fail_cnt saturates and never wraps, so zero still means "no failure yet"
            if (mism != '0) begin
               if (fail_cnt_q != CNT_SAT) fail_cnt_d = fail_cnt_q + 1'b1;
               if (fail_cnt_q == '0) begin
                  ff_step_d = step_idx_q;
                  ff_ch_d   = mism;
               end
            end
            if (bus.instr_complete) ov_d = 1'b1;
            step_idx_d = step_idx_q + 1'b1;
            if (step_idx_d == num_q) begin
               state_d = MON_WAIT_HALT;
               timer_d = '0;
            end else begin
               state_d = MON_WAIT_INSTR;
            end
         end
         MON_WAIT_HALT: begin
            if (bus.halt) begin
               state_d = MON_DONE;
            end else if (timer_q == TMR_LAST) begin
               to_d    = 1'b1;
               state_d = MON_DONE;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = MON_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= MON_IDLE;
         step_idx_q <= '0;
         num_q      <= '0;
         timer_q    <= '0;
         fail_cnt_q <= '0;
         ff_step_q  <= '1;
         ff_ch_q    <= '0;
         to_q       <= 1'b0;
         eh_q       <= 1'b0;
         ov_q       <= 1'b0;
      end else begin
         state_q    <= state_d;
         step_idx_q <= step_idx_d;
         num_q      <= num_d;
         timer_q    <= timer_d;
         fail_cnt_q <= fail_cnt_d;
         ff_step_q  <= ff_step_d;
         ff_ch_q    <= ff_ch_d;
         to_q       <= to_d;
         eh_q       <= eh_d;
         ov_q       <= ov_d;
      end
   end

   assign done            = (state_q == MON_DONE);
   assign pass            = done && (fail_cnt_q == '0) && !to_q && !eh_q;
   assign fail_count      = fail_cnt_q;
   assign first_fail_step = ff_step_q;
   assign first_fail_ch   = ff_ch_q;
   assign timeout_err     = to_q;
   assign early_halt_err  = eh_q;
   assign overrun_err     = ov_q;

endmodule

// File: tb/tb_instr_check_monitor.sv
// Directed bench for instr_check_monitor: a step-counting reference model checked
// every cycle, plus hand-computed literals for the headline scenarios.
module tb_instr_check_monitor;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       start;
   logic [4:0] num_steps;
   logic       busy, done, pass, timeout_err, early_halt_err, overrun_err;
   logic [4:0] fail_count, first_fail_step;
   logic [3:0] first_fail_ch;

   int vectors     = 0;
   int miscompares = 0;

   instr_check_monitor_if #(.DATA_WIDTH(8), .NUM_CH(4), .MAX_STEPS(16)) bus ();

   instr_check_monitor #(
      .DATA_WIDTH   (8),
      .NUM_CH       (4),
      .MAX_STEPS    (16),
      .HALT_TIMEOUT (20)
   ) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .start           (start),
      .num_steps       (num_steps),
      .bus             (bus),
      .busy            (busy),
      .done            (done),
      .pass            (pass),
      .fail_count      (fail_count),
      .first_fail_step (first_fail_step),
      .first_fail_ch   (first_fail_ch),
      .timeout_err     (timeout_err),
      .early_halt_err  (early_halt_err),
      .overrun_err     (overrun_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: counts checked steps against a target, tracks halt wait in cycles.
   logic [31:0] m_data [16];
   logic [3:0]  m_mask [16];
   bit          m_active, m_pending, m_finished;
   int          m_checked, m_target, m_wait;
   int          m_fails, m_first;
   logic [3:0]  m_first_ch;
   bit          m_to, m_eh, m_ov;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 16; i++) m_mask[i] = 4'b0;
         m_active = 0; m_pending = 0; m_finished = 0;
         m_checked = 0; m_target = 0; m_wait = 0;
         m_fails = 0; m_first = -1; m_first_ch = 4'b0;
         m_to = 0; m_eh = 0; m_ov = 0;
      end else if (!m_active) begin
         if (bus.exp_wr_en && bus.exp_wr_step < 16) begin
            m_data[bus.exp_wr_step[3:0]] = bus.exp_wr_data;
            m_mask[bus.exp_wr_step[3:0]] = bus.exp_wr_mask;
         end
         if (start) begin
            m_active = 1; m_pending = 0; m_finished = 0;
            m_checked = 0; m_wait = 0;
            m_target = (int'(num_steps) > 16) ? 16 : int'(num_steps);
            m_fails = 0; m_first = -1; m_first_ch = 4'b0;
            m_to = 0; m_eh = 0; m_ov = 0;
         end
      end else if (m_pending) begin
         logic [3:0] mm;
         mm = 4'b0;
         for (int c = 0; c < 4; c++) begin
            if (m_mask[m_checked][c] &&
                bus.ch_value[c*8 +: 8] != m_data[m_checked][c*8 +: 8]) mm[c] = 1'b1;
         end
         if (mm != 4'b0) begin
            if (m_first < 0) begin
               m_first    = m_checked;
               m_first_ch = mm;
            end
            if (m_fails < 31) m_fails++;
         end
         if (bus.instr_complete) m_ov = 1;
         m_checked++;
         m_pending = 0;
         m_wait    = 0;
      end else if (m_checked < m_target) begin
         if (bus.halt) begin
            m_eh = 1; m_active = 0; m_finished = 1;
         end else if (bus.instr_complete) begin
            m_pending = 1;
         end
      end else begin
         if (bus.halt) begin
            m_active = 0; m_finished = 1;
         end else begin
            m_wait++;
            if (m_wait == 20) begin
               m_to = 1; m_active = 0; m_finished = 1;
            end
         end
      end
   end

   always @(negedge clk) begin
      check("busy", busy, m_active);
      check("done", done, m_finished);
      check("pass", pass, m_finished && m_fails == 0 && !m_to && !m_eh);
      check("fail_count", fail_count, m_fails);
      check("first_fail_step", first_fail_step, (m_first < 0) ? 31 : m_first);
      check("first_fail_ch", first_fail_ch, m_first_ch);
      check("timeout_err", timeout_err, m_to);
      check("early_halt_err", early_halt_err, m_eh);
      check("overrun_err", overrun_err, m_ov);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_exp(input logic [4:0] step, input logic [31:0] data, input logic [3:0] mask);
      bus.exp_wr_en   = 1'b1;
      bus.exp_wr_step = step;
      bus.exp_wr_data = data;
      bus.exp_wr_mask = mask;
      tick();
      bus.exp_wr_en   = 1'b0;
   endtask

   task automatic arm(input logic [4:0] n);
      num_steps = n;
      start     = 1'b1;
      tick();
      start     = 1'b0;
   endtask

   task automatic retire(input logic [31:0] val);
      bus.ch_value       = val;
      bus.instr_complete = 1'b1;
      tick();
      bus.instr_complete = 1'b0;
      tick();
      tick();
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done && n < 60) begin
         tick();
         n++;
      end
      if (!done) check({name, "_done_within_bound"}, 0, 1);
   endtask

   initial begin
      int n;
      reset_n = 1'b0;
      start = 1'b0; num_steps = '0;
      bus.instr_complete = 1'b0; bus.halt = 1'b0; bus.ch_value = '0;
      bus.exp_wr_en = 1'b0; bus.exp_wr_step = '0; bus.exp_wr_data = '0; bus.exp_wr_mask = '0;
      repeat (3) tick();
      reset_n = 1'b1;
      check("lit_reset_ffs", first_fail_step, 5'h1F);
      check("lit_reset_busy", busy, 0);

      // Scenario 1: ADD_B program, all steps match; {flags,C,B,A}, flags N=bit1
      write_exp(5'd16, 32'hDEADBEEF, 4'b1111);
      write_exp(5'd0, 32'h00000001, 4'b0001);
      write_exp(5'd1, 32'h0200F400, 4'b1010);
      write_exp(5'd2, 32'h020000F5, 4'b1001);
      arm(5'd3);
      retire(32'h00000001);
      retire(32'h0200F401);
      retire(32'h0200F4F5);
      bus.halt = 1'b1;
      wait_done("t1");
      bus.halt = 1'b0;
      check("lit_t1_pass", pass, 1);
      check("lit_t1_fail_count", fail_count, 0);
      check("lit_t1_ffs", first_fail_step, 5'h1F);

      // Scenario 2: step 1 expects B=F5 but CPU shows F4
      write_exp(5'd1, 32'h0200F500, 4'b1010);
      arm(5'd3);
      retire(32'h00000001);
      retire(32'h0200F401);
      retire(32'h0200F4F5);
      bus.halt = 1'b1;
      wait_done("t2");
      bus.halt = 1'b0;
      check("lit_t2_pass", pass, 0);
      check("lit_t2_fail_count", fail_count, 1);
      check("lit_t2_ffs", first_fail_step, 1);
      check("lit_t2_ffc", first_fail_ch, 4'b0010);

      // Scenario 3: halt never comes; DONE 20 edges after the step-2 sample edge (n=1)
      arm(5'd2);
      retire(32'h00000001);
      bus.ch_value = 32'h0200F401;
      bus.instr_complete = 1'b1;
      tick();
      bus.instr_complete = 1'b0;
      n = 0;
      while (!done && n < 40) begin
         tick();
         n++;
      end
      check("lit_t3_cycles_to_done", n, 21);
      check("lit_t3_timeout", timeout_err, 1);
      check("lit_t3_pass", pass, 0);

      // Scenario 4: halt after the first retire of three
      arm(5'd3);
      retire(32'h00000001);
      bus.halt = 1'b1;
      wait_done("t4");
      bus.halt = 1'b0;
      check("lit_t4_early_halt", early_halt_err, 1);
      check("lit_t4_fail_count", fail_count, 0);
      check("lit_t4_done", done, 1);

      // Scenario 5: back-to-back retire pulses count as one step plus an overrun
      arm(5'd2);
      bus.ch_value = 32'h00000001;
      bus.instr_complete = 1'b1;
      tick();
      tick();
      bus.instr_complete = 1'b0;
      tick();
      tick();
      check("lit_t5_busy", busy, 1);
      bus.halt = 1'b1;
      wait_done("t5");
      bus.halt = 1'b0;
      check("lit_t5_overrun", overrun_err, 1);
      check("lit_t5_early_halt", early_halt_err, 1);

      // Scenario 6: async reset in the halt wait, then zero-step run with halt already high
      arm(5'd0);
      tick();
      tick();
      check("lit_t6_busy_before_reset", busy, 1);
      reset_n = 1'b0;
      #1;
      check("lit_t6_busy_in_reset", busy, 0);
      check("lit_t6_ffs_in_reset", first_fail_step, 5'h1F);
      check("lit_t6_done_in_reset", done, 0);
      tick();
      reset_n = 1'b1;
      bus.halt = 1'b1;
      arm(5'd0);
      check("lit_t6_done_after_1", done, 0);
      tick();
      check("lit_t6_done_after_2", done, 1);
      check("lit_t6_pass", pass, 1);
      bus.halt = 1'b0;
      tick();
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
